turfbus_master: RTL and testbench

TURF-side initiator for the TURFbus serial link. It accepts single WISHBONE classic-cycle transactions on a slave port and serializes each one onto TREQ_neg, one bit per clock. It then deserializes the SURF's reply from SREQ_neg and terminates the WISHBONE cycle with ack or err. It sits between the TURF's internal WISHBONE interconnect and the per-SURF TURFbus pins; the SURF-side bridge is its link partner.

---
 rtl/turfbus_master.sv | 173 +++++++++++++++++
 tb/tb_turfbus_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/turfbus_master.sv
// TURF-side TURFbus initiator: serializes one WISHBONE classic cycle onto TREQ_neg
// and terminates it with ack/err once the SURF reply arrives on SREQ_neg.
module turfbus_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [19:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    output logic        TREQ_neg,
    input  logic        SREQ_neg
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_STATUS,
        S_RX,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic [57:0] r_shreg;
    logic [5:0]  r_bitCnt;
    logic [TW-1:0] r_toCnt;
    logic        r_we;
    logic        r_abort;
    logic        r_rspErr;
    logic        r_sreqQ;
    logic        r_treqN;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_datO;

    assign TREQ_neg  = r_treqN;
    assign wbs_ack_o = r_ack;
    assign wbs_err_o = r_err;
    assign wbs_dat_o = r_datO;
    assign wbs_rty_o = 1'b0;

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The ack/err guard keeps a still-asserted stb from restarting the link in the termination cycle.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i && !r_ack && !r_err) begin
                    w_accept = 1'b1;
                    w_next   = S_TX;
                end
            end
            S_TX: begin
                if (r_bitCnt == (r_we ? 6'd57 : 6'd25)) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_sreqQ) begin
                    w_next = S_STATUS;
                end else if (r_toCnt == TW'(TIMEOUT - 1)) begin
                    w_next = S_DONE;
                end
            end
            S_STATUS: begin
                if (r_sreqQ || r_we) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RX;
                end
            end
            S_RX: begin
                if (r_bitCnt == 6'd31) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            r_shreg  <= '0;
            r_bitCnt <= '0;
            r_toCnt  <= '0;
            r_we     <= 1'b0;
            r_abort  <= 1'b0;
            r_rspErr <= 1'b0;
            r_sreqQ  <= 1'b0;
            r_treqN  <= 1'b1;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_datO   <= '0;
        end else begin
            r_sreqQ <= ~SREQ_neg;
            r_treqN <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            if (r_state != S_IDLE && !wbs_cyc_i) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg  <= wbs_we_i ? {2'b11, wbs_adr_i, wbs_sel_i, wbs_dat_i}
                                             : {2'b10, wbs_adr_i, wbs_sel_i, 32'h0};
                        r_we     <= wbs_we_i;
                        r_bitCnt <= '0;
                        r_abort  <= 1'b0;
                    end
                end
                S_TX: begin
                    r_treqN  <= ~r_shreg[57];
                    r_shreg  <= {r_shreg[56:0], 1'b0};
                    r_bitCnt <= r_bitCnt + 6'd1;
                    r_toCnt  <= '0;
                end
                S_WAIT: begin
                    r_toCnt  <= r_toCnt + 1'b1;
                    r_bitCnt <= '0;
                    r_rspErr <= ~r_sreqQ;
                end
                S_STATUS: begin
                    r_rspErr <= r_sreqQ;
                end
                S_RX: begin
                    r_shreg  <= {r_shreg[56:0], r_sreqQ};
                    r_bitCnt <= r_bitCnt + 6'd1;
                end
                S_DONE: begin
                    if (!r_abort && wbs_cyc_i) begin
                        if (r_rspErr) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ack <= 1'b1;
                            if (!r_we) begin
                                r_datO <= r_shreg[31:0];
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turfbus_master.sv
// Directed bench for turfbus_master: a table-driven WISHBONE master and SURF model,
// with per-cycle expectations derived from the link frame and timing rules.
module tb_turfbus_master;

    localparam int TMO = 16;
    localparam int NC  = 1024;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        cycI = 1'b0;
    logic        stbI = 1'b0;
    logic        weI = 1'b0;
    logic [19:0] adrI = '0;
    logic [31:0] datI = '0;
    logic [3:0]  selI = '0;
    logic [31:0] datO;
    logic        ackO;
    logic        errO;
    logic        rtyO;
    logic        treqN;
    logic        sreqN = 1'b1;

    int cycNum = 0;
    int checks = 0;
    int failures = 0;

    bit          cycA [NC];
    bit          weA  [NC];
    logic [19:0] adrA [NC];
    logic [3:0]  selA [NC];
    logic [31:0] datA [NC];
    bit          sreqA [NC];
    bit          expTreq [NC];
    bit          expAck [NC];
    bit          expErr [NC];
    bit          datSetV [NC];
    logic [31:0] datSetVal [NC];

    bit          treqB [NC];
    bit          ackH [NC];
    bit          errH [NC];
    logic [31:0] datH [NC];

    turfbus_master #(.TIMEOUT(TMO)) dut (
        .wbs_clk_i   (clk),
        .wbs_rst_n_i (rstN),
        .wbs_cyc_i   (cycI),
        .wbs_stb_i   (stbI),
        .wbs_we_i    (weI),
        .wbs_adr_i   (adrI),
        .wbs_dat_i   (datI),
        .wbs_sel_i   (selI),
        .wbs_dat_o   (datO),
        .wbs_ack_o   (ackO),
        .wbs_err_o   (errO),
        .wbs_rty_o   (rtyO),
        .TREQ_neg    (treqN),
        .SREQ_neg    (sreqN)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cycNum <= cycNum + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Schedule one transaction: WB inputs, SURF pin values and the expected outputs, by absolute edge.
    task automatic applyStimulus(input int c0, input bit we, input logic [19:0] adr,
                                 input logic [3:0] sel, input logic [31:0] dat, input int gap,
                                 input bit status, input logic [31:0] rdata, input int dropAt);
        int L;
        int E;
        int n;
        int D;
        logic [57:0] f;
        bit rdOk;
        bit isErr;
        bit on;
        L = we ? 58 : 26;
        f = we ? {2'b11, adr, sel, dat} : {32'h0, 2'b10, adr, sel};
        for (int k = 0; k < L; k++) expTreq[c0 + 1 + k] = ~f[L - 1 - k];
        E = c0 + L;
        rdOk = 1'b0;
        isErr = 1'b1;
        if (gap < 0) begin
            D = E + TMO + 1;
        end else begin
            n = E + gap;
            sreqA[n] = 1'b0;
            sreqA[n + 1] = ~status;
            rdOk = !we && !status;
            isErr = status;
            if (rdOk) begin
                for (int j = 0; j < 32; j++) sreqA[n + 2 + j] = ~rdata[31 - j];
                D = n + 35;
            end else begin
                D = n + 3;
            end
        end
        if (dropAt == 0) begin
            if (isErr) expErr[D] = 1'b1;
            else expAck[D] = 1'b1;
            if (rdOk) begin
                datSetV[D] = 1'b1;
                datSetVal[D] = rdata;
            end
        end
        for (int e = c0; e <= D; e++) begin
            on = (dropAt == 0) || (e < dropAt);
            cycA[e] = on;
            weA[e] = we;
            adrA[e] = adr;
            selA[e] = sel;
            datA[e] = dat;
        end
    endtask

    function automatic logic [57:0] grab(input int first, input int len);
        logic [57:0] w;
        w = '0;
        for (int k = 0; k < len; k++) w = {w[56:0], treqB[first + k]};
        return w;
    endfunction

    function automatic int pulses(input int lo, input int hi, input bit useAck);
        int cnt;
        cnt = 0;
        for (int c = lo; c <= hi; c++) cnt += useAck ? int'(ackH[c]) : int'(errH[c]);
        return cnt;
    endfunction

    // Inputs for edge e+1 are presented on the falling edge after edge e.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            e = cycNum + 1;
            if (e < NC) begin
                cycI  = cycA[e];
                stbI  = cycA[e];
                weI   = weA[e];
                adrI  = adrA[e];
                selI  = selA[e];
                datI  = datA[e];
                sreqN = sreqA[e];
            end
        end
    end

    // Per-cycle comparison against the model, sampled 2 ns after each rising edge.
    initial begin
        int c;
        logic [31:0] curDat;
        curDat = '0;
        forever begin
            @(posedge clk);
            #2;
            c = cycNum;
            if (c < NC) begin
                if (datSetV[c]) curDat = datSetVal[c];
                checkOutput($sformatf("treq@%0d", c), 64'(treqN), 64'(expTreq[c]));
                checkOutput($sformatf("ack@%0d", c), 64'(ackO), 64'(expAck[c]));
                checkOutput($sformatf("err@%0d", c), 64'(errO), 64'(expErr[c]));
                checkOutput($sformatf("dat@%0d", c), 64'(datO), 64'(curDat));
                checkOutput($sformatf("rty@%0d", c), 64'(rtyO), 64'd0);
                treqB[c] = ~treqN;
                ackH[c] = ackO;
                errH[c] = errO;
                datH[c] = datO;
            end
        end
    end

    initial begin
        logic [57:0] f8;
        for (int i = 0; i < NC; i++) begin
            sreqA[i] = 1'b1;
            expTreq[i] = 1'b1;
        end
        applyStimulus(5,   1'b1, 20'h12345, 4'hF, 32'hDEADBEEF, 10, 1'b0, 32'h0, 0);
        applyStimulus(80,  1'b0, 20'h00010, 4'hF, 32'h0, 10, 1'b0, 32'hCAFEF00D, 0);
        applyStimulus(160, 1'b0, 20'h00020, 4'hF, 32'h0, -1, 1'b0, 32'h0, 0);
        applyStimulus(210, 1'b0, 20'h00030, 4'hF, 32'h0, 5, 1'b1, 32'h0, 0);
        for (int j = 0; j < 4; j++) sreqA[243 + j] = 1'b0;
        applyStimulus(250, 1'b0, 20'h00005, 4'hF, 32'h0, 3, 1'b0, 32'h13579BDF, 0);
        applyStimulus(320, 1'b1, 20'hABCDE, 4'h3, 32'h0F1E2D3C, 6, 1'b0, 32'h0, 330);
        applyStimulus(395, 1'b1, 20'h00001, 4'h8, 32'h80000001, 1, 1'b0, 32'h0, 0);
        f8 = {2'b11, 20'h55555, 4'hF, 32'h12345678};
        for (int k = 0; k < 5; k++) expTreq[466 + k] = ~f8[57 - k];
        for (int e = 465; e <= 470; e++) begin
            cycA[e] = 1'b1;
            weA[e] = 1'b1;
            adrA[e] = 20'h55555;
            selA[e] = 4'hF;
            datA[e] = 32'h12345678;
        end
        datSetV[471] = 1'b1;
        datSetVal[471] = 32'h0;
        applyStimulus(480, 1'b0, 20'h00077, 4'hF, 32'h0, 2, 1'b0, 32'h0BADCAFE, 0);

        wait (cycNum == 2);
        @(negedge clk);
        rstN = 1'b1;

        wait (cycNum == 470);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("rst treq", 64'(treqN), 64'd1);
        checkOutput("rst ack", 64'(ackO), 64'd0);
        checkOutput("rst err", 64'(errO), 64'd0);
        checkOutput("rst dat", 64'(datO), 64'd0);
        wait (cycNum == 473);
        @(negedge clk);
        rstN = 1'b1;

        wait (cycNum == 560);
        #3;
        checkOutput("wr frame", 64'(grab(6, 58)), 64'(58'h312345FDEADBEEF));
        checkOutput("wr ack edge", 64'(ackH[76]), 64'd1);
        checkOutput("wr ack count", 64'(pulses(64, 79, 1'b1)), 64'd1);
        checkOutput("wr err count", 64'(pulses(64, 79, 1'b0)), 64'd0);
        checkOutput("rd frame", 64'(grab(81, 26)), 64'(26'h200010F));
        checkOutput("rd ack early", 64'(ackH[150]), 64'd0);
        checkOutput("rd ack edge", 64'(ackH[151]), 64'd1);
        checkOutput("rd data", 64'(datH[151]), 64'h00000000CAFEF00D);
        checkOutput("to err early", 64'(errH[202]), 64'd0);
        checkOutput("to err edge", 64'(errH[203]), 64'd1);
        checkOutput("to no ack", 64'(pulses(187, 209, 1'b1)), 64'd0);
        checkOutput("to data held", 64'(datH[205]), 64'h00000000CAFEF00D);
        checkOutput("st err edge", 64'(errH[244]), 64'd1);
        checkOutput("st no ack", 64'(pulses(237, 249, 1'b1)), 64'd0);
        checkOutput("rd5 ack", 64'(ackH[314]), 64'd1);
        checkOutput("rd5 data", 64'(datH[314]), 64'h0000000013579BDF);
        checkOutput("abort frame", 64'(grab(321, 58)), 64'(58'h3ABCDE30F1E2D3C));
        checkOutput("abort no ack", 64'(pulses(321, 394, 1'b1)), 64'd0);
        checkOutput("abort no err", 64'(pulses(321, 394, 1'b0)), 64'd0);
        checkOutput("post abort ack", 64'(ackH[457]), 64'd1);
        checkOutput("in reset dat", 64'(datH[472]), 64'd0);
        checkOutput("post rst ack", 64'(ackH[543]), 64'd1);
        checkOutput("post rst data", 64'(datH[543]), 64'h000000000BADCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
